// File: rtl/display_pkg.sv
// Shared display-path definitions: converter FSM encoding and BCD sizing helpers.
package display_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // Decimal digits needed to hold any bin_w-bit unsigned value (log10(2) ~= 0.301).
    function automatic int unsigned int_digits(input int unsigned bin_w);
        return (bin_w * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= DIGIT_W'(5)) ? digit_i + DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment scanner.
// Optional build macro BCD_SATURATE_EN: on overflow bcd_out shows all nines.
module bin_to_bcd_converter
    import display_pkg::*;
#(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned OUT_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          ready,
    output logic                          done,
    output logic [OUT_DIGITS*DIGIT_W-1:0] bcd_out,
    output logic                          overflow
);

    localparam int unsigned INT_DIGITS = int_digits(BIN_W);
    localparam int unsigned BCD_W      = INT_DIGITS * DIGIT_W;
    localparam int unsigned OUT_W      = OUT_DIGITS * DIGIT_W;
    localparam int unsigned SH_W       = BCD_W + BIN_W;
    localparam int unsigned CNT_W      = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [BCD_W-1:0] corr_bcd;
    logic [SH_W-1:0]  shifted;
    logic [OUT_W-1:0] low_digits;
    logic [OUT_W-1:0] result;
    logic             ovf_c;
    logic             last_c;

    for (genvar g = 0; g < int'(INT_DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (shreg_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .digit_o (corr_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One iteration: corrected digits plus binary remainder, shifted left by one.
    assign shifted    = SH_W'({corr_bcd, shreg_q[BIN_W-1:0]} << 1);
    assign low_digits = shifted[BIN_W +: OUT_W];
    assign last_c     = (cnt_q == CNT_W'(BIN_W - 1));

    if (INT_DIGITS > OUT_DIGITS) begin : g_ovf
        assign ovf_c = |shifted[SH_W-1:BIN_W+OUT_W];
    end else begin : g_no_ovf
        assign ovf_c = 1'b0;
    end

`ifdef BCD_SATURATE_EN
    assign result = ovf_c ? {OUT_DIGITS{DIGIT_W'(9)}} : low_digits;
`else
    assign result = low_digits;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)  state_d = ST_CONV;
            ST_CONV: if (last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        ready_d    = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = SH_W'(bin_in);
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    bcd_d      = result;
                    overflow_d = ovf_c;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter against an arithmetic decimal model.
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic        ready;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .ready    (ready),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, four shown, saturating when so built.
    function automatic logic [15:0] model_bcd(input int unsigned v);
        logic [15:0] r = '0;
        int unsigned m = v % 10000;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // One conversion; optionally pokes start with 42 during CONV and DONE.
    task automatic do_conv(input int unsigned v, input bit inject);
        int n;
        logic [15:0] prev;
        prev = bcd_out;
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        start  = 1'b1;
        bin_in = 16'(v);
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 16'($urandom);
        check("ready_after_accept", 32'(ready), 32'd0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            n = k;
            if (done) break;
            if (k == 8) check("bcd_held_in_conv", 32'(bcd_out), 32'(prev));
            if (inject && k == 5) begin start = 1'b1; bin_in = 16'd42; end
            if (inject && k == 6) start = 1'b0;
        end
        check("done_latency", 32'(n), 32'd16);
        check($sformatf("bcd_%0d", v), 32'(bcd_out), 32'(model_bcd(v)));
        check($sformatf("ovf_%0d", v), 32'(overflow), 32'(v > 9999));
        check("ready_in_done", 32'(ready), 32'd0);
        if (inject) begin start = 1'b1; bin_in = 16'd42; end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
        check("bcd_held_after_done", 32'(bcd_out), 32'(model_bcd(v)));
        if (inject) begin
            n = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (done) n++;
            end
            check("ignored_start_no_done", 32'(n), 32'd0);
            check("ignored_start_bcd", 32'(bcd_out), 32'(model_bcd(v)));
        end
    endtask

    initial begin
        int n;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #22 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Reset asserted mid-idle, then released with no start.
        #3 rst = 1'b0;
        #1;
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_bcd_stable", 32'(bcd_out), 32'h0);
        check("idle_done_stable", 32'(done), 32'd0);
        check("idle_ready_stable", 32'(ready), 32'd1);

        do_conv(1234, 1'b0);
        do_conv(0, 1'b0);
        do_conv(9999, 1'b0);
        do_conv(12345, 1'b0);
        do_conv(65535, 1'b0);
        do_conv(1234, 1'b1);

        // Reset in the middle of converting 4321.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(negedge clk) rst = 1'b1;
        n = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);
        check("abort_ready_after", 32'(ready), 32'd1);
        check("abort_bcd_after", 32'(bcd_out), 32'h0);

        // Randomized operands across the full range and the in-range subset.
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) do_conv($urandom_range(0, 65535), 1'b0);
            else            do_conv($urandom_range(0, 9999), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
